// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready flow-controlled ALU for the brimstone
// datapath. One-cycle latency with full throughput for logic, arithmetic,
// compare and shift ops; optional iterative shift-add multiplier.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> opcode 1100 runs a DATA_WIDTH_P-cycle shift-add multiply
//   undefined -> opcode 1100 is illegal and no multiplier logic is built
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   i_valid    operation presented
//   o_ready    block can accept an operation this cycle
//   i_control  4-bit opcode
//   i_a, i_b   operands (DATA_WIDTH_P)
//   i_tag      sideband tag, returned unchanged with the result
//   o_valid    result held on outputs
//   i_ready    downstream accepts the result
//   o_result   result (DATA_WIDTH_P)
//   o_tag      tag of the op that produced o_result
//   o_zero     o_result == 0
//   o_carry    carry out (ADD/SUB only)
//   o_ovf      signed overflow (ADD/SUB only)
//   o_err      illegal opcode
module alu_pipe #(
  parameter int DATA_WIDTH_P = 32,
  parameter int TAG_WIDTH_P  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [3:0]              i_control,
  input  logic [DATA_WIDTH_P-1:0] i_a,
  input  logic [DATA_WIDTH_P-1:0] i_b,
  input  logic [TAG_WIDTH_P-1:0]  i_tag,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH_P-1:0] o_result,
  output logic [TAG_WIDTH_P-1:0]  o_tag,
  output logic                    o_zero,
  output logic                    o_carry,
  output logic                    o_ovf,
  output logic                    o_err
);

  localparam int W   = DATA_WIDTH_P;
  localparam int SHW = $clog2(W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  logic [W-1:0]           result_q;
  logic [TAG_WIDTH_P-1:0] tag_q;
  logic                   valid_q, zero_q, carry_q, ovf_q, err_q;

  logic         outFree, accept, loadAlu;
  logic [W:0]   addFull, subFull;
  logic [SHW-1:0] shamt;
  logic [W-1:0] aluResult;
  logic         aluCarry, aluOvf, aluErr;

  // The output register is free when empty or being drained this cycle.
  assign outFree = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Extra top bit captures the carry out; SUB is a + ~b + 1.
  assign addFull = {1'b0, i_a} + {1'b0, i_b};
  assign subFull = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
  assign shamt   = i_b[SHW-1:0];

  // Single-cycle ALU function; anything unlisted (including MUL) flags err.
  always_comb begin
    aluResult = '0;
    aluCarry  = 1'b0;
    aluOvf    = 1'b0;
    aluErr    = 1'b0;
    case (i_control)
      OP_AND:  aluResult = i_a & i_b;
      OP_OR:   aluResult = i_a | i_b;
      OP_XOR:  aluResult = i_a ^ i_b;
      OP_ADD: begin
        aluResult = addFull[W-1:0];
        aluCarry  = addFull[W];
        aluOvf    = (i_a[W-1] == i_b[W-1]) && (addFull[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        aluResult = subFull[W-1:0];
        aluCarry  = subFull[W];
        aluOvf    = (i_a[W-1] != i_b[W-1]) && (subFull[W-1] != i_a[W-1]);
      end
      OP_SLTU: aluResult = {{(W-1){1'b0}}, (i_a < i_b)};
      OP_SLT:  aluResult = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLL:  aluResult = i_a << shamt;
      OP_SRL:  aluResult = i_a >> shamt;
      OP_SRA:  aluResult = $signed(i_a) >>> shamt;
      default: aluErr = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam int         CNT_W  = SHW + 1;

  typedef enum logic {IDLE, MUL} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           mcand_q, mplier_q, prod_q, prodNext, mulValue;
  logic [CNT_W-1:0]       mulCount_q;
  logic [TAG_WIDTH_P-1:0] mulTag_q;
  logic                   mulStart, loadMul, mulDone;

  assign o_ready  = outFree && (state_q == IDLE);
  assign prodNext = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mulDone  = (mulCount_q == CNT_W'(W));
  // After all bits are consumed the product is parked in prod_q.
  assign mulValue = mulDone ? prod_q : prodNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Last multiply step (or a parked product) unloads only into a free
  // output register; otherwise the FSM waits in MUL.
  always_comb begin
    state_d  = state_q;
    loadAlu  = 1'b0;
    loadMul  = 1'b0;
    mulStart = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_control == OP_MUL) begin
            mulStart = 1'b1;
            state_d  = MUL;
          end else begin
            loadAlu = 1'b1;
          end
        end
      end
      MUL: begin
        if ((mulCount_q >= CNT_W'(W - 1)) && outFree) begin
          loadMul = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit per cycle, low W bits kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      mulCount_q <= '0;
      mulTag_q   <= '0;
    end else if (mulStart) begin
      mcand_q    <= i_a;
      mplier_q   <= i_b;
      prod_q     <= '0;
      mulCount_q <= '0;
      mulTag_q   <= i_tag;
    end else if ((state_q == MUL) && !mulDone) begin
      prod_q     <= prodNext;
      mcand_q    <= mcand_q << 1;
      mplier_q   <= mplier_q >> 1;
      mulCount_q <= mulCount_q + CNT_W'(1);
    end
  end
`else
  assign o_ready = outFree;
  assign loadAlu = accept;
`endif

  // Output register: loads on a completed op, otherwise holds until drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (loadAlu) begin
      valid_q  <= 1'b1;
      result_q <= aluResult;
      tag_q    <= i_tag;
      zero_q   <= (aluResult == '0);
      carry_q  <= aluCarry;
      ovf_q    <= aluOvf;
      err_q    <= aluErr;
`ifdef ALU_MUL_EN
    end else if (loadMul) begin
      valid_q  <= 1'b1;
      result_q <= mulValue;
      tag_q    <= mulTag_q;
      zero_q   <= (mulValue == '0);
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else if (i_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_tag    = tag_q;
  assign o_zero   = zero_q;
  assign o_carry  = carry_q;
  assign o_ovf    = ovf_q;
  assign o_err    = err_q;

endmodule
